// File: rtl/mem_arbiter.sv
// mem_arbiter
//
// Shares one cache-line memory port between the I-cache and the D-cache.
// One requester is granted at a time; its address, write line and command
// are latched on the grant edge and drive the memory port until memory
// signals completion. Simultaneous requests alternate between the caches.
//
// Handshake (both caches): a cache raises its enable and holds it with a
// stable address/data until it sees its one-cycle ready pulse. The ready
// pulse is combinational from in_mem_ready while that cache owns the port.
// The arbiter stores no request: whatever is high in IDLE is what competes.
//
// Ports
//   clk, reset              single clock, synchronous active-high reset
//   in_icache_*             I-cache line read request and address
//   out_icache_read_data/ready   line and completion pulse to I-cache
//   in_dcache_*             D-cache fill/writeback request, address, line
//   out_dcache_read_data/ready   line and completion pulse to D-cache
//   out_mem_*               memory command, address and write line
//   in_mem_read_data/ready  memory read line and completion pulse
//   out_grant               00 none, 01 I-cache, 10 D-cache
//   out_dbg_state           current FSM state (IDLE=0, SERVE_I=1, SERVE_D=2, RELEASE=3)

module mem_arbiter #(
    parameter int CACHE_LINE_SIZE = 128
) (
    input  logic                       clk,
    input  logic                       reset,

    input  logic                       in_icache_read_en,
    input  logic [31:0]                in_icache_addr,
    output logic [CACHE_LINE_SIZE-1:0] out_icache_read_data,
    output logic                       out_icache_ready,

    input  logic                       in_dcache_read_en,
    input  logic                       in_dcache_write_en,
    input  logic [31:0]                in_dcache_addr,
    input  logic [CACHE_LINE_SIZE-1:0] in_dcache_write_data,
    output logic [CACHE_LINE_SIZE-1:0] out_dcache_read_data,
    output logic                       out_dcache_ready,

    output logic                       out_mem_read_en,
    output logic                       out_mem_write_en,
    output logic [31:0]                out_mem_addr,
    output logic [CACHE_LINE_SIZE-1:0] out_mem_write_data,
    input  logic [CACHE_LINE_SIZE-1:0] in_mem_read_data,
    input  logic                       in_mem_ready,

    output logic [1:0]                 out_grant,
    output logic [1:0]                 out_dbg_state
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2,
        RELEASE = 2'd3
    } state_t;

    state_t                     state_q, state_d;
    logic                       last_d_q, last_d_d;   // 1: most recent grant went to the D-cache
    logic [31:0]                addr_q, addr_d;
    logic [CACHE_LINE_SIZE-1:0] wdata_q, wdata_d;
    logic                       rd_q, rd_d;
    logic                       wr_q, wr_d;

    logic                       i_req, d_req;
    logic                       grant_i, grant_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            last_d_q <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            last_d_q <= last_d_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rd_q     <= rd_d;
            wr_q     <= wr_d;
        end
    end

    always_comb begin
        state_d              = state_q;
        last_d_d             = last_d_q;
        addr_d               = addr_q;
        wdata_d              = wdata_q;
        rd_d                 = rd_q;
        wr_d                 = wr_q;
        i_req                = in_icache_read_en;
        d_req                = in_dcache_read_en | in_dcache_write_en;
        grant_i              = 1'b0;
        grant_d              = 1'b0;
        out_mem_read_en      = 1'b0;
        out_mem_write_en     = 1'b0;
        out_grant            = 2'b00;
        out_icache_ready     = 1'b0;
        out_dcache_ready     = 1'b0;
        out_icache_read_data = '0;
        out_dcache_read_data = '0;

        unique case (state_q)
            IDLE: begin
                // On a tie the cache that did not win last time goes next.
                if (i_req && d_req) begin
                    grant_d = ~last_d_q;
                    grant_i = last_d_q;
                end else begin
                    grant_i = i_req;
                    grant_d = d_req;
                end

                if (grant_i) begin
                    state_d  = SERVE_I;
                    last_d_d = 1'b0;
                    addr_d   = in_icache_addr;
                    wdata_d  = '0;
                    rd_d     = 1'b1;
                    wr_d     = 1'b0;
                end else if (grant_d) begin
                    state_d  = SERVE_D;
                    last_d_d = 1'b1;
                    addr_d   = in_dcache_addr;
                    wdata_d  = in_dcache_write_data;
                    // Both D enables high is illegal; treat it as a writeback only.
                    wr_d     = in_dcache_write_en;
                    rd_d     = ~in_dcache_write_en;
                end
            end

            SERVE_I, SERVE_D: begin
                out_mem_read_en  = rd_q;
                out_mem_write_en = wr_q;
                out_grant        = (state_q == SERVE_I) ? 2'b01 : 2'b10;
                if (in_mem_ready) begin
                    state_d = RELEASE;
                    // A completion arriving while reset is asserted is dropped.
                    if (state_q == SERVE_I) begin
                        out_icache_ready     = ~reset;
                        out_icache_read_data = in_mem_read_data;
                    end else begin
                        out_dcache_ready     = ~reset;
                        out_dcache_read_data = in_mem_read_data;
                    end
                end
            end

            RELEASE: begin
                // One dead cycle lets the owner drop its enable before IDLE samples it.
                state_d = IDLE;
            end

            default: state_d = IDLE;
        endcase
    end

    assign out_mem_addr       = addr_q;
    assign out_mem_write_data = wdata_q;
    assign out_dbg_state      = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter. Inputs are driven 1 ns after the rising edge,
// outputs are sampled 4 ns after the rising edge.

module tb_mem_arbiter;

    localparam int W = 128;

    logic           clk = 1'b0;
    logic           reset;
    logic           in_icache_read_en;
    logic [31:0]    in_icache_addr;
    logic [W-1:0]   out_icache_read_data;
    logic           out_icache_ready;
    logic           in_dcache_read_en;
    logic           in_dcache_write_en;
    logic [31:0]    in_dcache_addr;
    logic [W-1:0]   in_dcache_write_data;
    logic [W-1:0]   out_dcache_read_data;
    logic           out_dcache_ready;
    logic           out_mem_read_en;
    logic           out_mem_write_en;
    logic [31:0]    out_mem_addr;
    logic [W-1:0]   out_mem_write_data;
    logic [W-1:0]   in_mem_read_data;
    logic           in_mem_ready;
    logic [1:0]     out_grant;
    logic [1:0]     out_dbg_state;

    int             checks = 0;
    int             failures = 0;
    bit             model_last_d;        // 1 when the latest grant went to the D-cache
    logic [W-1:0]   exp_q[$];            // expected read lines, one per completion

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #500000;
        failures++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    mem_arbiter #(.CACHE_LINE_SIZE(W)) dut (
        .clk                  (clk),
        .reset                (reset),
        .in_icache_read_en    (in_icache_read_en),
        .in_icache_addr       (in_icache_addr),
        .out_icache_read_data (out_icache_read_data),
        .out_icache_ready     (out_icache_ready),
        .in_dcache_read_en    (in_dcache_read_en),
        .in_dcache_write_en   (in_dcache_write_en),
        .in_dcache_addr       (in_dcache_addr),
        .in_dcache_write_data (in_dcache_write_data),
        .out_dcache_read_data (out_dcache_read_data),
        .out_dcache_ready     (out_dcache_ready),
        .out_mem_read_en      (out_mem_read_en),
        .out_mem_write_en     (out_mem_write_en),
        .out_mem_addr         (out_mem_addr),
        .out_mem_write_data   (out_mem_write_data),
        .in_mem_read_data     (in_mem_read_data),
        .in_mem_ready         (in_mem_ready),
        .out_grant            (out_grant),
        .out_dbg_state        (out_dbg_state)
    );

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_icache_read_en    = 1'b0;
        in_icache_addr       = '0;
        in_dcache_read_en    = 1'b0;
        in_dcache_write_en   = 1'b0;
        in_dcache_addr       = '0;
        in_dcache_write_data = '0;
        in_mem_read_data     = '0;
        in_mem_ready         = 1'b0;
    endtask

    function automatic logic [W-1:0] rand_line();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // ---------------- scenarios ----------------
    task automatic test_reset();
        logic [W-1:0] line;
        idle_inputs();
        reset             = 1'b1;
        in_icache_read_en = 1'b1;
        in_icache_addr    = 32'h0000_0040;
        in_dcache_read_en = 1'b1;
        in_dcache_addr    = 32'h0000_0080;
        in_mem_ready      = 1'b1;
        tick();
        tick();
        #3;
        checks++;
        if ({out_mem_read_en, out_mem_write_en, out_icache_ready, out_dcache_ready} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_ctrl: rd/wr/irdy/drdy=%b required 0000",
                     {out_mem_read_en, out_mem_write_en, out_icache_ready, out_dcache_ready});
        end
        checks++;
        if (out_grant !== 2'b00) begin
            failures++;
            $display("FAIL reset_grant: got %b required 00", out_grant);
        end
        checks++;
        if (out_mem_addr !== 32'h0 || out_mem_write_data !== '0) begin
            failures++;
            $display("FAIL reset_latch: addr=%h wdata=%h required 0", out_mem_addr, out_mem_write_data);
        end
        tick();
        reset        = 1'b0;
        in_mem_ready = 1'b0;
        #3;
        checks++;
        if (out_grant !== 2'b00 || out_mem_read_en !== 1'b0) begin
            failures++;
            $display("FAIL post_reset_idle: grant=%b rd=%b required 00/0", out_grant, out_mem_read_en);
        end
        tick();
        #3;
        // First tie after reset goes to the D-cache.
        checks++;
        if (out_grant !== 2'b10 || out_mem_read_en !== 1'b1 || out_mem_addr !== 32'h80) begin
            failures++;
            $display("FAIL first_tie: grant=%b rd=%b addr=%h required 10/1/00000080",
                     out_grant, out_mem_read_en, out_mem_addr);
        end
        model_last_d = 1'b1;
        tick();
        line             = rand_line();
        in_mem_ready     = 1'b1;
        in_mem_read_data = line;
        exp_q.push_back(line);
        #3;
        checks++;
        if (out_dcache_ready !== 1'b1 || out_icache_ready !== 1'b0 || out_dcache_read_data !== exp_q.pop_front()) begin
            failures++;
            $display("FAIL first_tie_done: drdy=%b irdy=%b data=%h", out_dcache_ready, out_icache_ready,
                     out_dcache_read_data);
        end
        tick();
        in_dcache_read_en = 1'b0;
        in_mem_ready      = 1'b0;
        #3;
        checks++;
        if (out_grant !== 2'b00 || out_mem_read_en !== 1'b0) begin
            failures++;
            $display("FAIL first_tie_release: grant=%b rd=%b required 00/0", out_grant, out_mem_read_en);
        end
        tick();
        tick();
        #3;
        checks++;
        if (out_grant !== 2'b01 || out_mem_addr !== 32'h40) begin
            failures++;
            $display("FAIL held_i_served: grant=%b addr=%h required 01/00000040", out_grant, out_mem_addr);
        end
        model_last_d = 1'b0;
        tick();
        in_mem_ready = 1'b1;
        tick();
        idle_inputs();
        tick();
    endtask

    task automatic test_icache_read();
        logic [W-1:0] line;
        line              = {4{32'hA5A5_A5A5}};
        in_icache_read_en = 1'b1;
        in_icache_addr    = 32'h0000_0100;
        tick();
        for (int c = 1; c <= 3; c++) begin
            // A D-cache request that comes and goes while busy must be forgotten.
            in_dcache_read_en = (c == 1);
            in_mem_ready      = (c == 3);
            in_mem_read_data  = (c == 3) ? line : '0;
            #3;
            checks++;
            if (out_mem_read_en !== 1'b1 || out_mem_write_en !== 1'b0 || out_mem_addr !== 32'h100 ||
                out_grant !== 2'b01) begin
                failures++;
                $display("FAIL iread_cycle%0d: rd=%b wr=%b addr=%h grant=%b required 1/0/00000100/01",
                         c, out_mem_read_en, out_mem_write_en, out_mem_addr, out_grant);
            end
            checks++;
            if (out_icache_ready !== (c == 3) || out_dcache_ready !== 1'b0) begin
                failures++;
                $display("FAIL iread_ready%0d: irdy=%b drdy=%b required %0d/0",
                         c, out_icache_ready, out_dcache_ready, (c == 3));
            end
            if (c == 3) begin
                checks++;
                if (out_icache_read_data !== line) begin
                    failures++;
                    $display("FAIL iread_data: got %h required %h", out_icache_read_data, line);
                end
            end
            tick();
        end
        in_icache_read_en = 1'b0;
        in_mem_ready      = 1'b0;
        #3;
        checks++;
        if (out_mem_read_en !== 1'b0 || out_grant !== 2'b00 || out_icache_ready !== 1'b0) begin
            failures++;
            $display("FAIL iread_release: rd=%b grant=%b irdy=%b required 0/00/0",
                     out_mem_read_en, out_grant, out_icache_ready);
        end
        model_last_d = 1'b0;
        tick();
        tick();
        #3;
        checks++;
        if (out_grant !== 2'b00 || out_mem_read_en !== 1'b0) begin
            failures++;
            $display("FAIL dropped_req_served: grant=%b rd=%b required 00/0", out_grant, out_mem_read_en);
        end
        tick();
    endtask

    task automatic test_dcache_write();
        logic [W-1:0] wline;
        wline                = {4{32'h1234_5678}};
        in_dcache_write_en   = 1'b1;
        in_dcache_addr       = 32'h0000_2000;
        in_dcache_write_data = wline;
        tick();
        for (int c = 1; c <= 3; c++) begin
            if (c == 2) begin
                in_dcache_addr       = 32'h0000_3000;
                in_dcache_write_data = ~wline;
            end
            in_mem_ready     = (c == 3);
            in_mem_read_data = rand_line();
            #3;
            checks++;
            if (out_mem_write_en !== 1'b1 || out_mem_read_en !== 1'b0 || out_mem_addr !== 32'h2000 ||
                out_mem_write_data !== wline || out_grant !== 2'b10) begin
                failures++;
                $display("FAIL dwrite_cycle%0d: wr=%b rd=%b addr=%h wdata=%h grant=%b required 1/0/00002000/%h/10",
                         c, out_mem_write_en, out_mem_read_en, out_mem_addr, out_mem_write_data, out_grant, wline);
            end
            checks++;
            if (out_dcache_ready !== (c == 3) || out_icache_ready !== 1'b0) begin
                failures++;
                $display("FAIL dwrite_ready%0d: drdy=%b irdy=%b required %0d/0",
                         c, out_dcache_ready, out_icache_ready, (c == 3));
            end
            tick();
        end
        in_dcache_write_en = 1'b0;
        in_mem_ready       = 1'b0;
        #3;
        checks++;
        if (out_mem_write_en !== 1'b0 || out_mem_addr !== 32'h2000 || out_mem_write_data !== wline) begin
            failures++;
            $display("FAIL dwrite_release: wr=%b addr=%h wdata=%h required 0/00002000/%h",
                     out_mem_write_en, out_mem_addr, out_mem_write_data, wline);
        end
        model_last_d = 1'b1;
        tick();
        idle_inputs();
    endtask

    task automatic test_spurious_ready();
        in_mem_ready     = 1'b1;
        in_mem_read_data = rand_line();
        #3;
        checks++;
        if (out_icache_ready !== 1'b0 || out_dcache_ready !== 1'b0 || out_grant !== 2'b00) begin
            failures++;
            $display("FAIL spurious_ready: irdy=%b drdy=%b grant=%b required 0/0/00",
                     out_icache_ready, out_dcache_ready, out_grant);
        end
        tick();
        in_mem_ready = 1'b0;
        #3;
        checks++;
        if (out_grant !== 2'b00 || out_mem_read_en !== 1'b0 || out_mem_write_en !== 1'b0) begin
            failures++;
            $display("FAIL spurious_after: grant=%b rd=%b wr=%b required 00/0/0",
                     out_grant, out_mem_read_en, out_mem_write_en);
        end
        tick();
    endtask

    task automatic test_mid_reset();
        logic [W-1:0] line;
        in_icache_read_en = 1'b1;
        in_icache_addr    = 32'h0000_0500;
        tick();
        #3;
        checks++;
        if (out_mem_read_en !== 1'b1 || out_grant !== 2'b01) begin
            failures++;
            $display("FAIL midrst_serve: rd=%b grant=%b required 1/01", out_mem_read_en, out_grant);
        end
        tick();
        reset            = 1'b1;
        in_mem_ready     = 1'b1;
        in_mem_read_data = rand_line();
        #3;
        checks++;
        if (out_icache_ready !== 1'b0 || out_dcache_ready !== 1'b0) begin
            failures++;
            $display("FAIL midrst_no_ready: irdy=%b drdy=%b required 0/0", out_icache_ready, out_dcache_ready);
        end
        tick();
        reset          = 1'b0;
        in_mem_ready   = 1'b0;
        in_icache_addr = 32'h0000_0600;
        #3;
        checks++;
        if (out_mem_read_en !== 1'b0 || out_grant !== 2'b00 || out_mem_addr !== 32'h0) begin
            failures++;
            $display("FAIL midrst_after: rd=%b grant=%b addr=%h required 0/00/00000000",
                     out_mem_read_en, out_grant, out_mem_addr);
        end
        tick();
        #3;
        checks++;
        if (out_grant !== 2'b01 || out_mem_read_en !== 1'b1 || out_mem_addr !== 32'h600) begin
            failures++;
            $display("FAIL midrst_fresh: grant=%b rd=%b addr=%h required 01/1/00000600",
                     out_grant, out_mem_read_en, out_mem_addr);
        end
        model_last_d = 1'b0;
        tick();
        line             = rand_line();
        in_mem_ready     = 1'b1;
        in_mem_read_data = line;
        #3;
        checks++;
        if (out_icache_ready !== 1'b1 || out_icache_read_data !== line) begin
            failures++;
            $display("FAIL midrst_fresh_done: irdy=%b data=%h required 1/%h",
                     out_icache_ready, out_icache_read_data, line);
        end
        tick();
        idle_inputs();
        tick();
    endtask

    // Rounds of random traffic checked against the arbitration rules: a lone
    // request wins, a tie goes to whoever did not win last, the loser keeps
    // its request up, and every transaction has a fixed shape in cycles.
    task automatic test_arbitration(input int rounds, input bit contention);
        bit           pend_i, pend_d, win_d, prev_win_d, have_prev;
        logic [31:0]  i_addr, d_addr, exp_addr;
        logic [W-1:0] d_wdata, line;
        int           d_cmd, lat;
        bit           exp_rd, exp_wr;
        pend_i    = 1'b0;
        pend_d    = 1'b0;
        have_prev = 1'b0;
        prev_win_d = 1'b0;
        i_addr    = '0;
        d_addr    = '0;
        d_wdata   = '0;
        d_cmd     = 0;
        for (int r = 0; r < rounds; r++) begin
            if (!pend_i && (contention || $urandom_range(0, 2) != 0)) begin
                pend_i = 1'b1;
                i_addr = $urandom;
            end
            if (!pend_d && (contention || !pend_i || $urandom_range(0, 2) != 0)) begin
                pend_d  = 1'b1;
                d_addr  = $urandom;
                d_wdata = rand_line();
                d_cmd   = $urandom_range(0, 2);   // 0 fill, 1 writeback, 2 both (illegal)
            end
            in_icache_read_en    = pend_i;
            in_icache_addr       = i_addr;
            in_dcache_read_en    = pend_d && (d_cmd != 1);
            in_dcache_write_en   = pend_d && (d_cmd != 0);
            in_dcache_addr       = d_addr;
            in_dcache_write_data = d_wdata;
            in_mem_ready         = ($urandom_range(0, 3) == 0);
            #3;
            checks++;
            if (out_grant !== 2'b00 || out_icache_ready !== 1'b0 || out_dcache_ready !== 1'b0) begin
                failures++;
                $display("FAIL arb_idle r%0d: grant=%b irdy=%b drdy=%b required 00/0/0",
                         r, out_grant, out_icache_ready, out_dcache_ready);
            end

            win_d        = pend_d && (!pend_i || !model_last_d);
            model_last_d = win_d;
            exp_addr     = win_d ? d_addr : i_addr;
            exp_wr       = win_d && (d_cmd != 0);
            exp_rd       = !exp_wr;
            if (contention && have_prev) begin
                checks++;
                if (win_d == prev_win_d) begin
                    failures++;
                    $display("FAIL arb_repeat r%0d: same requester chosen twice (d=%0d)", r, win_d);
                end
            end
            prev_win_d = win_d;
            have_prev  = 1'b1;
            lat        = $urandom_range(1, 4);
            tick();

            for (int c = 1; c <= lat; c++) begin
                in_mem_ready = (c == lat);
                line         = rand_line();
                in_mem_read_data = line;
                if (c == lat) exp_q.push_back(line);
                // The owner may scramble or drop its inputs mid-transaction.
                if (c > 1 && $urandom_range(0, 2) == 0) begin
                    if (win_d) begin
                        in_dcache_addr       = $urandom;
                        in_dcache_write_data = rand_line();
                        if ($urandom_range(0, 1) == 0) begin
                            in_dcache_read_en  = 1'b0;
                            in_dcache_write_en = 1'b0;
                        end
                    end else begin
                        in_icache_addr = $urandom;
                        if ($urandom_range(0, 1) == 0) in_icache_read_en = 1'b0;
                    end
                end
                #3;
                checks++;
                if (out_grant !== (win_d ? 2'b10 : 2'b01) || out_mem_read_en !== exp_rd ||
                    out_mem_write_en !== exp_wr || out_mem_addr !== exp_addr) begin
                    failures++;
                    $display("FAIL arb_serve r%0d c%0d: grant=%b rd=%b wr=%b addr=%h required %b/%b/%b/%h",
                             r, c, out_grant, out_mem_read_en, out_mem_write_en, out_mem_addr,
                             win_d ? 2'b10 : 2'b01, exp_rd, exp_wr, exp_addr);
                end
                if (exp_wr) begin
                    checks++;
                    if (out_mem_write_data !== d_wdata) begin
                        failures++;
                        $display("FAIL arb_wdata r%0d: got %h required %h", r, out_mem_write_data, d_wdata);
                    end
                end
                checks++;
                if (out_icache_ready !== (!win_d && c == lat) || out_dcache_ready !== (win_d && c == lat)) begin
                    failures++;
                    $display("FAIL arb_ready r%0d c%0d: irdy=%b drdy=%b required %0d/%0d",
                             r, c, out_icache_ready, out_dcache_ready, (!win_d && c == lat), (win_d && c == lat));
                end
                if (c == lat) begin
                    line = exp_q.pop_front();
                    checks++;
                    if ((win_d ? out_dcache_read_data : out_icache_read_data) !== line) begin
                        failures++;
                        $display("FAIL arb_rdata r%0d: got %h required %h", r,
                                 win_d ? out_dcache_read_data : out_icache_read_data, line);
                    end
                end
                tick();
            end

            // Release cycle: owner drops its request, loser keeps it up.
            if (win_d) begin
                pend_d             = 1'b0;
                in_dcache_read_en  = 1'b0;
                in_dcache_write_en = 1'b0;
            end else begin
                pend_i            = 1'b0;
                in_icache_read_en = 1'b0;
            end
            in_mem_ready = ($urandom_range(0, 1) == 0);
            #3;
            checks++;
            if (out_grant !== 2'b00 || out_mem_read_en !== 1'b0 || out_mem_write_en !== 1'b0 ||
                out_icache_ready !== 1'b0 || out_dcache_ready !== 1'b0 || out_mem_addr !== exp_addr) begin
                failures++;
                $display("FAIL arb_release r%0d: grant=%b rd=%b wr=%b irdy=%b drdy=%b addr=%h required 00/0/0/0/0/%h",
                         r, out_grant, out_mem_read_en, out_mem_write_en, out_icache_ready,
                         out_dcache_ready, out_mem_addr, exp_addr);
            end
            tick();
        end
        idle_inputs();
        tick();
        tick();
    endtask

    // ---------------- sequence and final report ----------------
    initial begin
        model_last_d = 1'b0;
        test_reset();
        test_icache_read();
        test_dcache_write();
        test_spurious_ready();
        test_mid_reset();
        test_arbitration(10, 1'b1);
        test_arbitration(40, 1'b0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
